// File: rtl/reg_bus_sequencer.sv
// Round-robin sequencer for register-to-register moves on a shared tri-state bus.
// Break-before-make: the source drives for a full Tick period before the destination loads.
module reg_bus_sequencer #(
    parameter int NrOfRegs = 8,
    parameter int SelBits  = 3
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Tick,
    input  logic [1:0]          req,
    input  logic [SelBits-1:0]  src0,
    input  logic [SelBits-1:0]  dst0,
    input  logic [SelBits-1:0]  src1,
    input  logic [SelBits-1:0]  dst1,
    output logic [NrOfRegs-1:0] cs,
    output logic [NrOfRegs-1:0] ClockEnable,
    output logic [1:0]          ack,
    output logic                err,
    output logic                busy,
    output logic [1:0]          state_dbg
);

    // Handshake: a requester raises req[i] with stable src/dst and holds it until
    // ack[i] pulses for one Clock; it drops req[i] in the cycle after that pulse.

    typedef enum logic [1:0] {IDLE, DRIVE, LOAD, ACK} state_t;

    localparam logic [NrOfRegs-1:0] lsb = {{(NrOfRegs-1){1'b0}}, 1'b1};

    state_t               state;
    logic                 id;
    logic                 rr;
    logic                 bad;
    logic [SelBits-1:0]   src;
    logic [SelBits-1:0]   dst;

    logic                 pick;
    logic [SelBits-1:0]   pick_src;
    logic [SelBits-1:0]   pick_dst;
    logic                 pick_bad;

    // On a tie the requester that was not served last wins.
    always_comb begin
        pick     = (req == 2'b11) ? ~rr : req[1];
        pick_src = pick ? src1 : src0;
        pick_dst = pick ? dst1 : dst0;
        pick_bad = (int'(pick_src) >= NrOfRegs) || (int'(pick_dst) >= NrOfRegs);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state       <= IDLE;
            cs          <= '1;
            ClockEnable <= '0;
            ack         <= 2'b00;
            err         <= 1'b0;
            busy        <= 1'b0;
            rr          <= 1'b1;
            id          <= 1'b0;
            bad         <= 1'b0;
            src         <= '0;
            dst         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Tick && (req != 2'b00)) begin
                        id   <= pick;
                        rr   <= pick;
                        src  <= pick_src;
                        dst  <= pick_dst;
                        bad  <= pick_bad;
                        busy <= 1'b1;
                        if (pick_bad) begin
                            state <= ACK;
                            ack   <= pick ? 2'b10 : 2'b01;
                            err   <= 1'b1;
                        end else begin
                            state <= DRIVE;
                            cs    <= ~(lsb << pick_src);
                        end
                    end
                end
                DRIVE: begin
                    if (Tick) begin
                        state       <= LOAD;
                        ClockEnable <= lsb << dst;
                    end
                end
                // The destination captures on the Tick edge that leaves LOAD.
                LOAD: begin
                    if (Tick) begin
                        state       <= ACK;
                        cs          <= '1;
                        ClockEnable <= '0;
                        ack         <= id ? 2'b10 : 2'b01;
                        err         <= bad;
                    end
                end
                ACK: begin
                    state <= IDLE;
                    ack   <= 2'b00;
                    err   <= 1'b0;
                    bad   <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign state_dbg = state;

endmodule
